input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3: number of independent input channels, 1..32.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth, 2..4.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a change, >=1.
REQ-004 The block SHALL have parameter ACTIVE_LOW_MASK, default all-ones of NUM_CH bits: bit i=1 means raw_in[i] is asserted low.
REQ-005 The block SHALL have parameter BLINK_CYCLES, default 12_500_000: LED blink half-period in clocks, >=1.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock, rising-edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port raw_in, input, NUM_CH bits: raw, asynchronous, bouncing pins (joystick, buttons).
REQ-009 The block SHALL have port clear_inputs, input, NUM_CH bits: per-channel clear of the latched press.
REQ-010 The block SHALL have port level, output, NUM_CH bits: debounced, active-high channel state.
REQ-011 The block SHALL have port pressed_pulse, output, NUM_CH bits: one-cycle pulse on debounced assertion.
REQ-012 The block SHALL have port pressed_latched, output, NUM_CH bits: sticky press flag, held until cleared.
REQ-013 The block SHALL have port led_mode, input, 2 bits: 00 off, 01 on, 10 blink, 11 follow level[0].
REQ-014 The block SHALL have port LED, output, 1 bit: registered, active-high LED drive.

Function
REQ-015 Each channel SHALL be normalised to active-high as raw_in[i] XOR ACTIVE_LOW_MASK[i] before synchronization.
REQ-016 Each normalised channel SHALL pass through a SYNC_STAGES-deep flop chain; no other logic SHALL read unsynchronized input.
REQ-017 Each channel SHALL hold a debounce counter of width $clog2(DEBOUNCE_CYCLES+1), cleared whenever synchronized value equals level[i].
REQ-018 Counter SHALL increment while synchronized value differs from level[i]; level[i] SHALL toggle and counter clear on the cycle it would reach DEBOUNCE_CYCLES.
REQ-019 A clean raw edge SHALL appear on level at the (SYNC_STAGES + DEBOUNCE_CYCLES)th rising clock edge after the edge; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never reach level.
REQ-020 pressed_pulse[i] SHALL be high for exactly one cycle, the first cycle level[i] is 1; release SHALL produce no pulse.
REQ-021 pressed_latched[i] SHALL set in the cycle after pressed_pulse[i] and stay set until clear_inputs[i] is sampled high.
REQ-022 Simultaneous set and clear_inputs[i] on one edge SHALL leave pressed_latched[i] set; no press SHALL be lost.
REQ-023 clear_inputs[i] SHALL affect only channel i and SHALL NOT alter level or the debounce counter.
REQ-024 LED SHALL be registered: 00 -> 0, 01 -> 1, 11 -> level[0] delayed one cycle, 10 -> toggles every BLINK_CYCLES clocks starting at 1.
REQ-025 The blink counter SHALL restart at 0, with LED=1, on the cycle after led_mode changes to 10, and wrap at BLINK_CYCLES-1.

Reset
REQ-026 Reset SHALL asynchronously force all sync flops, counters, level, pressed_pulse, pressed_latched and LED to 0; the blink counter to 0.
REQ-027 Reset asserted mid-debounce SHALL discard partial counts; after release, a held input SHALL again need the full REQ-019 latency.

Structure
REQ-028 Package input_conditioner_pkg SHALL hold led_mode_t enum (LED_OFF, LED_ON, LED_BLINK, LED_FOLLOW) and default parameter constants.
REQ-029 Per-channel sync+debounce+edge logic SHALL be sub-module debouncer, instantiated NUM_CH times by a generate loop.

Verification (NUM_CH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, BLINK_CYCLES=5, mask 3'b111)
REQ-030 raw_in[0] 1->0 held -> level[0]=1 at edge 6, pressed_pulse[0] high one cycle, pressed_latched[0]=1 from edge 7.
REQ-031 raw_in[1] low-pulses of 1, 2 and 3 cycles -> level[1], pressed_pulse[1] and pressed_latched[1] stay 0.
REQ-032 pressed_latched[2]=1, clear_inputs=3'b100 one cycle -> latched[2]=0 next cycle, level[2] unchanged; repeat with clear coincident to new pulse -> latched[2] stays 1.
REQ-033 led_mode=10 for 20 cycles -> LED pattern 1x5, 0x5, 1x5, 0x5; led_mode=11 -> LED tracks level[0] one cycle late.
REQ-034 Reset asserted 2 cycles into a 4-cycle debounce -> all outputs 0 immediately; after release with input held, level rises 6 edges later.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared types and default constants for the input conditioner.
// cnt_width gives the bit width needed to count from 0 up to max_count.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        LED_OFF    = 2'b00,
        LED_ON     = 2'b01,
        LED_BLINK  = 2'b10,
        LED_FOLLOW = 2'b11
    } led_mode_t;

    localparam int DEF_NUM_CH          = 3;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_BLINK_CYCLES    = 12_500_000;

    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_debouncer.sv
// One channel: synchronizer chain, debounce counter, press pulse and sticky press flag.
// Expects an already active-high input; the top applies the polarity mask.
module debouncer
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    input  logic clear,
    output logic level,
    output logic pressed_pulse,
    output logic pressed_latched
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   level_reg, level_next;
    logic                   pulse_reg, pulse_next;
    logic                   latched_reg, latched_next;
    logic                   synced;

    assign synced = sync_reg[SYNC_STAGES-1];

    always_comb begin
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        pulse_next   = 1'b0;
        latched_next = latched_reg;

        if (synced == level_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            // Accept the change on the cycle the count would reach DEBOUNCE_CYCLES.
            cnt_next   = '0;
            level_next = ~level_reg;
            pulse_next = ~level_reg;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end

        // A new press wins over a coincident clear so no press is lost.
        if (pulse_reg) begin
            latched_next = 1'b1;
        end else if (clear) begin
            latched_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg    <= '0;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            pulse_reg   <= 1'b0;
            latched_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], din};
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            pulse_reg   <= pulse_next;
            latched_reg <= latched_next;
        end
    end

    assign level           = level_reg;
    assign pressed_pulse   = pulse_reg;
    assign pressed_latched = latched_reg;

endmodule

// File: rtl/input_conditioner.sv
// Conditions NUM_CH raw pins into debounced levels, press pulses and sticky press flags,
// and drives a status LED that can be off, on, blinking or following channel 0.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int                NUM_CH          = DEF_NUM_CH,
    parameter int                SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = '1,
    parameter int                BLINK_CYCLES    = DEF_BLINK_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic [NUM_CH-1:0] clear_inputs,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] pressed_pulse,
    output logic [NUM_CH-1:0] pressed_latched,
    input  logic [1:0]        led_mode,
    output logic              LED
);

    localparam int BW = cnt_width(BLINK_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [NUM_CH-1:0] norm;

    assign norm = raw_in ^ ACTIVE_LOW_MASK;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            debouncer #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clock           (clock),
                .reset           (reset),
                .din             (norm[gi]),
                .clear           (clear_inputs[gi]),
                .level           (level[gi]),
                .pressed_pulse   (pressed_pulse[gi]),
                .pressed_latched (pressed_latched[gi])
            );
        end
    endgenerate

    led_mode_t       mode;
    led_mode_t       mode_prev_reg;
    logic [BW-1:0]   blink_reg, blink_next;
    logic            led_reg, led_next;

    assign mode = led_mode_t'(led_mode);

    always_comb begin
        led_next   = led_reg;
        blink_next = '0;
        case (mode)
            LED_OFF:    led_next = 1'b0;
            LED_ON:     led_next = 1'b1;
            LED_FOLLOW: led_next = level[0];
            LED_BLINK: begin
                // Entering blink mode restarts the half-period with the LED lit.
                if (mode_prev_reg != LED_BLINK) begin
                    led_next = 1'b1;
                end else if (blink_reg == BLINK_LAST) begin
                    led_next = ~led_reg;
                end else begin
                    blink_next = blink_reg + 1'b1;
                end
            end
            default:    led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_prev_reg <= LED_OFF;
            blink_reg     <= '0;
            led_reg       <= 1'b0;
        end else begin
            mode_prev_reg <= mode;
            blink_reg     <= blink_next;
            led_reg       <= led_next;
        end
    end

    assign LED = led_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench: expected output snapshots are queued ahead of the stimulus and
// compared one per clock against {level, pressed_pulse, pressed_latched, LED}.
module tb_input_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] raw_in = 3'b111;
    logic [2:0] clear_inputs = 3'b000;
    logic [2:0] level;
    logic [2:0] pressed_pulse;
    logic [2:0] pressed_latched;
    logic [1:0] led_mode = 2'b00;
    logic       LED;

    input_conditioner #(
        .NUM_CH          (3),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW_MASK (3'b111),
        .BLINK_CYCLES    (5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .raw_in          (raw_in),
        .clear_inputs    (clear_inputs),
        .level           (level),
        .pressed_pulse   (pressed_pulse),
        .pressed_latched (pressed_latched),
        .led_mode        (led_mode),
        .LED             (LED)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } exp_t;

    exp_t sb[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    logic [9:0] obs;
    assign obs = {level, pressed_pulse, pressed_latched, LED};

    task automatic push(input string tag, input logic [2:0] lv, input logic [2:0] pp,
                        input logic [2:0] pl, input logic led);
        exp_t e;
        e.tag = tag;
        e.exp = {lv, pp, pl, led};
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check();
        exp_t e;
        assert_count++;
        if (sb.size() == 0) begin
            fail_count++;
            $error("FAIL scoreboard_underflow observed=%b expected=<queued entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                fail_count++;
                $error("FAIL %s observed lv/pp/pl/led=%b expected=%b", e.tag, obs, e.exp);
            end
            $display("%0t check %s lv/pp/pl/led=%b", $time, e.tag, obs);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check();
        end
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #2;
        push("reset_async", 3'b000, 3'b000, 3'b000, 1'b0);
        check();
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) push("idle", 3'b000, 3'b000, 3'b000, 1'b0);
        run(3);

        // Channel 0 clean press: level at edge 6, pulse once, latched from edge 7
        raw_in = 3'b110;
        for (int i = 1; i <= 5; i++) push($sformatf("a_press_e%0d", i), 3'b000, 3'b000, 3'b000, 1'b0);
        push("a_press_e6", 3'b001, 3'b001, 3'b000, 1'b0);
        push("a_press_e7", 3'b001, 3'b000, 3'b001, 1'b0);
        push("a_press_e8", 3'b001, 3'b000, 3'b001, 1'b0);
        run(8);

        // Release: level falls at edge 6, no pulse, latch held
        raw_in = 3'b111;
        for (int i = 1; i <= 5; i++) push($sformatf("a_rel_e%0d", i), 3'b001, 3'b000, 3'b001, 1'b0);
        for (int i = 6; i <= 8; i++) push($sformatf("a_rel_e%0d", i), 3'b000, 3'b000, 3'b001, 1'b0);
        run(8);
        clear_inputs = 3'b001;
        push("a_clear", 3'b000, 3'b000, 3'b000, 1'b0);
        run(1);
        clear_inputs = 3'b000;

        // Channel 1 glitches of 1..3 cycles never reach level
        for (int w = 1; w <= 3; w++) begin
            for (int i = 0; i < w + 8; i++)
                push($sformatf("b_glitch%0d_e%0d", w, i + 1), 3'b000, 3'b000, 3'b000, 1'b0);
            raw_in = 3'b101;
            for (int i = 0; i < w + 8; i++) begin
                tick();
                check();
                if (i == w - 1) raw_in = 3'b111;
            end
        end

        // Channel 1 pulse of exactly 4 cycles is accepted, then released 4 cycles later
        for (int i = 1; i <= 5; i++) push($sformatf("b_w4_e%0d", i), 3'b000, 3'b000, 3'b000, 1'b0);
        push("b_w4_e6", 3'b010, 3'b010, 3'b000, 1'b0);
        for (int i = 7; i <= 9; i++) push($sformatf("b_w4_e%0d", i), 3'b010, 3'b000, 3'b010, 1'b0);
        for (int i = 10; i <= 12; i++) push($sformatf("b_w4_e%0d", i), 3'b000, 3'b000, 3'b010, 1'b0);
        raw_in = 3'b101;
        for (int i = 0; i < 12; i++) begin
            tick();
            check();
            if (i == 3) raw_in = 3'b111;
        end
        clear_inputs = 3'b010;
        push("b_clear", 3'b000, 3'b000, 3'b000, 1'b0);
        run(1);
        clear_inputs = 3'b000;

        // Channel 2: press, clear leaves level alone
        raw_in = 3'b011;
        for (int i = 1; i <= 5; i++) push($sformatf("c_press_e%0d", i), 3'b000, 3'b000, 3'b000, 1'b0);
        push("c_press_e6", 3'b100, 3'b100, 3'b000, 1'b0);
        push("c_press_e7", 3'b100, 3'b000, 3'b100, 1'b0);
        push("c_press_e8", 3'b100, 3'b000, 3'b100, 1'b0);
        run(8);
        clear_inputs = 3'b100;
        push("c_clear", 3'b100, 3'b000, 3'b000, 1'b0);
        run(1);
        clear_inputs = 3'b000;
        push("c_after_clear1", 3'b100, 3'b000, 3'b000, 1'b0);
        push("c_after_clear2", 3'b100, 3'b000, 3'b000, 1'b0);
        run(2);

        // Release, then press again with clear coincident to the latch set
        raw_in = 3'b111;
        for (int i = 1; i <= 5; i++) push($sformatf("c_rel_e%0d", i), 3'b100, 3'b000, 3'b000, 1'b0);
        for (int i = 6; i <= 8; i++) push($sformatf("c_rel_e%0d", i), 3'b000, 3'b000, 3'b000, 1'b0);
        run(8);
        raw_in = 3'b011;
        for (int i = 1; i <= 5; i++) push($sformatf("c_re_e%0d", i), 3'b000, 3'b000, 3'b000, 1'b0);
        push("c_re_e6", 3'b100, 3'b100, 3'b000, 1'b0);
        run(6);
        clear_inputs = 3'b100;
        push("c_coincident_set", 3'b100, 3'b000, 3'b100, 1'b0);
        run(1);
        clear_inputs = 3'b000;
        push("c_coincident_hold1", 3'b100, 3'b000, 3'b100, 1'b0);
        push("c_coincident_hold2", 3'b100, 3'b000, 3'b100, 1'b0);
        run(2);

        // LED blink: 1x5, 0x5, 1x5, 0x5
        led_mode = 2'b10;
        for (int i = 0; i < 20; i++)
            push($sformatf("d_blink_%0d", i + 1), 3'b100, 3'b000, 3'b100, ((i / 5) % 2) == 0);
        run(20);

        // LED follows level[0] one cycle late
        led_mode = 2'b11;
        raw_in   = 3'b010;
        for (int i = 1; i <= 5; i++) push($sformatf("d_follow_e%0d", i), 3'b100, 3'b000, 3'b100, 1'b0);
        push("d_follow_e6", 3'b101, 3'b001, 3'b100, 1'b0);
        push("d_follow_e7", 3'b101, 3'b000, 3'b101, 1'b1);
        push("d_follow_e8", 3'b101, 3'b000, 3'b101, 1'b1);
        run(8);
        led_mode = 2'b00;
        push("d_led_off", 3'b101, 3'b000, 3'b101, 1'b0);
        run(1);
        led_mode = 2'b01;
        push("d_led_on", 3'b101, 3'b000, 3'b101, 1'b1);
        run(1);

        // Reset two cycles into a debounce, then the full latency again
        raw_in = 3'b000;
        for (int i = 1; i <= 4; i++) push($sformatf("e_pre_e%0d", i), 3'b101, 3'b000, 3'b101, 1'b1);
        run(4);
        reset = 1'b1;
        #1;
        push("e_reset_async", 3'b000, 3'b000, 3'b000, 1'b0);
        check();
        tick();
        push("e_reset_held", 3'b000, 3'b000, 3'b000, 1'b0);
        check();
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) push($sformatf("e_post_e%0d", i), 3'b000, 3'b000, 3'b000, 1'b1);
        push("e_post_e6", 3'b111, 3'b111, 3'b000, 1'b1);
        push("e_post_e7", 3'b111, 3'b000, 3'b111, 1'b1);
        push("e_post_e8", 3'b111, 3'b000, 3'b111, 1'b1);
        run(8);

        assert_count++;
        assert (sb.size() == 0) else begin
            fail_count++;
            $error("FAIL scoreboard_drain observed=%0d entries expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
